// File: rtl/array_wr_pkg.sv
// Shared types and helpers for the burst array writer: FSM state encoding,
// default array geometry and the index bounds check used on both ports.
package array_wr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } wr_state_e;

   localparam int ARRAY_DEPTH = 4;
   localparam int ARRAY_WIDTH = 32;

   function automatic logic in_bounds(input logic [31:0] idx, input int unsigned depth);
      return (idx < depth);
   endfunction

endpackage

// File: rtl/array_store.sv
// Fixed storage array with a synchronous, reset-cleared write port and a
// bounds-checked combinational read port; out-of-range accesses never touch mem.
module array_store
   import array_wr_pkg::*;
#(
   parameter int DEPTH = ARRAY_DEPTH,
   parameter int WIDTH = ARRAY_WIDTH,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_oob
);

   localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SEL_W-1:0] wr_sel;
   logic [SEL_W-1:0] rd_sel;
   logic             wr_ok;
   logic             rd_ok;

   // Low index bits only select an entry once the full index passed the bounds check.
   assign wr_sel = wr_idx[SEL_W-1:0];
   assign rd_sel = rd_idx[SEL_W-1:0];
   assign wr_ok  = in_bounds(32'(wr_idx), DEPTH);
   assign rd_ok  = in_bounds(32'(rd_idx), DEPTH);

   // Write port: reset clears every entry, otherwise in-bounds writes only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_en && wr_ok) begin
         mem[wr_sel] <= wr_data;
      end
   end

   // Read port: returns zero and flags out-of-range indices.
   always_comb begin
      rd_data = {WIDTH{1'b0}};
      rd_oob  = !rd_ok;
      if (rd_ok) begin
         rd_data = mem[rd_sel];
      end else begin
         rd_data = {WIDTH{1'b0}};
      end
   end

endmodule

// File: rtl/array_burst_writer.sv
// Burst writer filling a fixed array from a valid/ready stream with index
// auto-increment. Define ARRAY_WR_WRAP_EN to wrap indices modulo DEPTH instead of dropping.
module array_burst_writer
   import array_wr_pkg::*;
#(
   parameter int DEPTH = ARRAY_DEPTH,
   parameter int WIDTH = ARRAY_WIDTH,
   parameter int IDX_W = 4,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W-1:0] base_idx,
   input  logic [LEN_W-1:0] len,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   output logic             busy,
   output logic             done,
   output logic             oob_err,
   output logic [LEN_W-1:0] oob_count,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_oob
);

   wr_state_e        state;
   logic [IDX_W-1:0] cur_idx;
   logic [LEN_W-1:0] remaining;
   logic [IDX_W-1:0] start_idx;
   logic [IDX_W-1:0] next_idx;
   logic [IDX_W-1:0] rd_sel_idx;
   logic             beat_oob;
   logic             xfer;

`ifdef ARRAY_WR_WRAP_EN
   // Every index is folded into 0..DEPTH-1, so no beat is ever out of bounds.
   assign start_idx  = base_idx % IDX_W'(DEPTH);
   assign next_idx   = (cur_idx == IDX_W'(DEPTH - 1)) ? {IDX_W{1'b0}} : cur_idx + IDX_W'(1);
   assign beat_oob   = 1'b0;
   assign rd_sel_idx = rd_idx % IDX_W'(DEPTH);
`else
   // The index saturates at all-ones so a long burst can never wrap back into range.
   assign start_idx  = base_idx;
   assign next_idx   = (&cur_idx) ? cur_idx : cur_idx + IDX_W'(1);
   assign beat_oob   = !in_bounds(32'(cur_idx), DEPTH);
   assign rd_sel_idx = rd_idx;
`endif

   assign wr_ready = (state == BURST);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign xfer     = wr_valid && wr_ready;

   // Burst sequencing, index/beat counters and out-of-bound accounting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_idx   <= {IDX_W{1'b0}};
         remaining <= {LEN_W{1'b0}};
         oob_err   <= 1'b0;
         oob_count <= {LEN_W{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cur_idx   <= start_idx;
                  remaining <= len;
                  oob_err   <= 1'b0;
                  oob_count <= {LEN_W{1'b0}};
                  state     <= (len != {LEN_W{1'b0}}) ? BURST : DONE;
               end
            end
            BURST: begin
               if (xfer) begin
                  cur_idx   <= next_idx;
                  remaining <= remaining - LEN_W'(1);
                  if (beat_oob) begin
                     oob_err <= 1'b1;
                     if (!(&oob_count)) begin
                        oob_count <= oob_count + LEN_W'(1);
                     end
                  end
                  if (remaining == LEN_W'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   array_store #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (xfer),
      .wr_idx  (cur_idx),
      .wr_data (wr_data),
      .rd_idx  (rd_sel_idx),
      .rd_data (rd_data),
      .rd_oob  (rd_oob)
   );

endmodule

// File: tb/tb_array_burst_writer.sv
// Directed self-checking bench for array_burst_writer; expected values are
// hand-computed, with alternate expectations when ARRAY_WR_WRAP_EN is defined.
module tb_array_burst_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  base_idx;
   logic [3:0]  len;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        busy;
   logic        done;
   logic        oob_err;
   logic [3:0]  oob_count;
   logic [3:0]  rd_idx;
   logic [31:0] rd_data;
   logic        rd_oob;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_mem [4];

   array_burst_writer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_idx  (base_idx),
      .len       (len),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .busy      (busy),
      .done      (done),
      .oob_err   (oob_err),
      .oob_count (oob_count),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .rd_oob    (rd_oob)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 4; i++) begin
         rd_idx = 4'(i);
         #1;
         check($sformatf("%s_mem%0d", tag, i), rd_data, exp_mem[i]);
      end
      rd_idx = 4'd0;
   endtask

   task automatic check_oob(input string tag, input logic e_err, input logic [3:0] e_cnt);
      check($sformatf("%s_oob_err", tag), {31'd0, oob_err}, {31'd0, e_err});
      check($sformatf("%s_oob_count", tag), {28'd0, oob_count}, {28'd0, e_cnt});
   endtask

   // Start a burst, present beats following vpat (bit c = valid in cycle c), check handshake and done.
   task automatic run_burst(input string tag, input logic [3:0] b, input logic [3:0] l,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [7:0] vpat, input int ncyc, input logic poke_start);
      logic [31:0] d [4];
      int k;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      k = 0;
      start = 1'b1; base_idx = b; len = l;
      tick();
      start = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         check($sformatf("%s_ready%0d", tag, c), {31'd0, wr_ready}, 32'd1);
         check($sformatf("%s_nodone%0d", tag, c), {31'd0, done}, 32'd0);
         wr_valid = vpat[c];
         wr_data  = (k < 4) ? d[k] : 32'd0;
         if (poke_start && c == 1) begin
            start = 1'b1; base_idx = 4'd3; len = 4'd1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (vpat[c]) k++;
      end
      wr_valid = 1'b0;
      start    = 1'b0;
      check($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
      check($sformatf("%s_busy_done", tag), {31'd0, busy}, 32'd1);
      check($sformatf("%s_ready_done", tag), {31'd0, wr_ready}, 32'd0);
      if (poke_start) begin
         start = 1'b1; base_idx = 4'd0; len = 4'd0;
      end
      tick();
      start = 1'b0;
      check($sformatf("%s_done_clr", tag), {31'd0, done}, 32'd0);
      check($sformatf("%s_idle", tag), {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_idx = 4'd0; len = 4'd0;
      wr_valid = 1'b0; wr_data = 32'd0; rd_idx = 4'd0;
      for (int i = 0; i < 4; i++) exp_mem[i] = 32'd0;

      // Reset state
      tick();
      tick();
      check("rst_ready", {31'd0, wr_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check_oob("rst", 1'b0, 4'd0);
      check_mem("rst");
      rst_n = 1'b1;
      tick();

      // Basic in-range burst
      run_burst("t1", 4'd0, 4'd4, 32'd1, 32'd0, 32'd0, 32'd1, 8'h0F, 4, 1'b0);
      exp_mem[0] = 32'd1; exp_mem[1] = 32'd0; exp_mem[2] = 32'd0; exp_mem[3] = 32'd1;
      check_mem("t1");
      check_oob("t1", 1'b0, 4'd0);

      // Burst crossing the end of the array
      run_burst("t2", 4'd2, 4'd4, 32'hA, 32'hB, 32'hC, 32'hD, 8'h0F, 4, 1'b0);
`ifdef ARRAY_WR_WRAP_EN
      exp_mem[0] = 32'hC; exp_mem[1] = 32'hD; exp_mem[2] = 32'hA; exp_mem[3] = 32'hB;
      check_oob("t2", 1'b0, 4'd0);
      rd_idx = 4'd4;
      #1;
      check("t2_rd4_data", rd_data, 32'hC);
      check("t2_rd4_oob", {31'd0, rd_oob}, 32'd0);
`else
      exp_mem[2] = 32'hA; exp_mem[3] = 32'hB;
      check_oob("t2", 1'b1, 4'd2);
      rd_idx = 4'd4;
      #1;
      check("t2_rd4_data", rd_data, 32'd0);
      check("t2_rd4_oob", {31'd0, rd_oob}, 32'd1);
      rd_idx = 4'd9;
      #1;
      check("t2_rd9_oob", {31'd0, rd_oob}, 32'd1);
`endif
      rd_idx = 4'd3;
      #1;
      check("t2_rd3_oob", {31'd0, rd_oob}, 32'd0);
      check_mem("t2");

      // Zero-length burst: done right away, no write even with valid high
      wr_valid = 1'b1; wr_data = 32'hDEAD;
      run_burst("t3", 4'd1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, 0, 1'b0);
      check_mem("t3");
      check_oob("t3", 1'b0, 4'd0);

      // Base beyond the array; index saturates near all-ones
      run_burst("t4", 4'd14, 4'd3, 32'h55, 32'h66, 32'h77, 32'd0, 8'h07, 3, 1'b0);
`ifdef ARRAY_WR_WRAP_EN
      exp_mem[2] = 32'h55; exp_mem[3] = 32'h66; exp_mem[0] = 32'h77;
      check_oob("t4", 1'b0, 4'd0);
`else
      check_oob("t4", 1'b1, 4'd3);
`endif
      check_mem("t4");

      // Gappy valid with start poked mid-burst and in DONE
      run_burst("t5", 4'd0, 4'd4, 32'd5, 32'd6, 32'd7, 32'd8, 8'h39, 6, 1'b1);
      exp_mem[0] = 32'd5; exp_mem[1] = 32'd6; exp_mem[2] = 32'd7; exp_mem[3] = 32'd8;
      check_mem("t5");
      check_oob("t5", 1'b0, 4'd0);

      // Reset mid-burst after two beats (second beat is out of range without wrap)
      start = 1'b1; base_idx = 4'd3; len = 4'd4;
      tick();
      start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check($sformatf("t6_ready%0d", c), {31'd0, wr_ready}, 32'd1);
         wr_valid = 1'b1;
         wr_data  = 32'd9 + 32'(c);
         tick();
      end
      wr_valid = 1'b0;
`ifndef ARRAY_WR_WRAP_EN
      check_oob("t6_pre", 1'b1, 4'd1);
`endif
      rst_n = 1'b0;
      tick();
      check("t6_rst_ready", {31'd0, wr_ready}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_done", {31'd0, done}, 32'd0);
      check_oob("t6_rst", 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) exp_mem[i] = 32'd0;
      check_mem("t6_rst");
      rst_n = 1'b1;
      tick();
      check("t6_nodone", {31'd0, done}, 32'd0);
      check("t6_idle", {31'd0, busy}, 32'd0);

      run_burst("t7", 4'd1, 4'd2, 32'h11, 32'h22, 32'd0, 32'd0, 8'h03, 2, 1'b0);
      exp_mem[1] = 32'h11; exp_mem[2] = 32'h22;
      check_mem("t7");
      check_oob("t7", 1'b0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
